// File: rtl/lpddr_phy_cfg_apb3_initiator.sv
// lpddr_phy_cfg_apb3_initiator
// Converts single-beat valid/ready register requests into APB3 transfers on
// the LPDDR PHY configuration port, returns read data/error status and keeps
// saturating transaction and error counters.
// Optional feature: define LPDDR_PHY_CFG_APB_TIMEOUT_EN to bound the ACCESS
// phase to TimeoutCycles wait cycles (aborted transfers report a timeout).
//
// Handshakes: a request transfers on a cycle where i_req_valid && o_req_ready;
// a response transfers on a cycle where o_rsp_valid && i_rsp_ready. Once
// o_rsp_valid rises it stays high, with a stable payload, until consumed.
module lpddr_phy_cfg_apb3_initiator #(
    parameter int AddrW         = 32,
    parameter int DataW         = 32,
    parameter int CntW          = 32,
    parameter int TimeoutCycles = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic             i_req_write,
    input  logic [AddrW-1:0] i_req_addr,
    input  logic [DataW-1:0] i_req_wdata,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [DataW-1:0] o_rsp_rdata,
    output logic             o_rsp_error,
    output logic             o_rsp_timeout,
    output logic             o_psel,
    output logic             o_penable,
    output logic             o_pwrite,
    output logic [AddrW-1:0] o_paddr,
    output logic [DataW-1:0] o_pwdata,
    input  logic             i_pready,
    input  logic [DataW-1:0] i_prdata,
    input  logic             i_pslverr,
    input  logic             i_cnt_clr,
    output logic [CntW-1:0]  o_txn_cnt,
    output logic [CntW-1:0]  o_err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_write;
    logic [AddrW-1:0] r_addr;
    logic [DataW-1:0] r_wdata;
    logic [DataW-1:0] r_rdata;
    logic             r_err;
    logic [CntW-1:0]  r_txn_cnt;
    logic [CntW-1:0]  r_err_cnt;
    logic             w_accept;
    logic             w_timeout_hit;
    logic             w_access_done;
    logic             w_done_err;

    assign w_accept = (r_state == ST_IDLE) && i_req_valid;

`ifdef LPDDR_PHY_CFG_APB_TIMEOUT_EN
    localparam int TW = $clog2(TimeoutCycles + 1);

    logic [TW-1:0] r_wait_cnt;
    logic          r_timeout;

    // Counts completed ACCESS wait cycles; restarts on every SETUP.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_SETUP) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ST_ACCESS) && !i_pready) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // The current cycle is the TimeoutCycles-th wait cycle; pready on it still wins.
    assign w_timeout_hit = (r_state == ST_ACCESS) && !i_pready &&
                           (r_wait_cnt == TW'(TimeoutCycles - 1));

    // Timeout flag of the response, captured at ACCESS exit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_timeout <= 1'b0;
        end else if (w_access_done) begin
            r_timeout <= !i_pready;
        end
    end

    assign o_rsp_timeout = r_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign o_rsp_timeout = 1'b0;
`endif

    assign w_access_done = (r_state == ST_ACCESS) && (i_pready || w_timeout_hit);
    // A timeout exit is always an error; a normal exit carries PSLVERR.
    assign w_done_err    = i_pready ? i_pslverr : 1'b1;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (i_req_valid) w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (w_access_done) w_state_nxt = ST_RESP;
            ST_RESP:   if (i_rsp_ready) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Request register; held from SETUP through the end of the transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_write <= i_req_write;
            r_addr  <= i_req_addr;
            r_wdata <= i_req_wdata;
        end
    end

    // Response payload, captured only on the cycle ACCESS exits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_access_done) begin
            r_rdata <= (i_pready && !r_write) ? i_prdata : '0;
            r_err   <= w_done_err;
        end
    end

    // Saturating counters; clear overrides a same-cycle increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_txn_cnt <= '0;
            r_err_cnt <= '0;
        end else if (i_cnt_clr) begin
            r_txn_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_access_done) begin
            if (r_txn_cnt != '1) begin
                r_txn_cnt <= r_txn_cnt + 1'b1;
            end
            if (w_done_err && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign o_req_ready = (r_state == ST_IDLE);
    assign o_psel      = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
    assign o_penable   = (r_state == ST_ACCESS);
    assign o_rsp_valid = (r_state == ST_RESP);
    assign o_pwrite    = r_write;
    assign o_paddr     = r_addr;
    assign o_pwdata    = r_wdata;
    assign o_rsp_rdata = r_rdata;
    assign o_rsp_error = r_err;
    assign o_txn_cnt   = r_txn_cnt;
    assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_lpddr_phy_cfg_apb3_initiator.sv
// Bench for lpddr_phy_cfg_apb3_initiator: directed and random APB3 transfers
// checked against a transaction-level model (expected read-data queue plus
// saturating integer counters). Inputs are driven and outputs sampled on the
// falling clock edge.
module tb_lpddr_phy_cfg_apb3_initiator;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int CW   = 4;
  localparam int TO   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_req_valid = 1'b0;
  logic          o_req_ready;
  logic          i_req_write = 1'b0;
  logic [AW-1:0] i_req_addr = '0;
  logic [DW-1:0] i_req_wdata = '0;
  logic          o_rsp_valid;
  logic          i_rsp_ready = 1'b0;
  logic [DW-1:0] o_rsp_rdata;
  logic          o_rsp_error;
  logic          o_rsp_timeout;
  logic          o_psel;
  logic          o_penable;
  logic          o_pwrite;
  logic [AW-1:0] o_paddr;
  logic [DW-1:0] o_pwdata;
  logic          i_pready = 1'b0;
  logic [DW-1:0] i_prdata = '0;
  logic          i_pslverr = 1'b0;
  logic          i_cnt_clr = 1'b0;
  logic [CW-1:0] o_txn_cnt;
  logic [CW-1:0] o_err_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [DW-1:0] exp_q[$];
  int exp_txn = 0;
  int exp_err = 0;

  // clock / reset block
  always #5 clk = ~clk;

  lpddr_phy_cfg_apb3_initiator #(
    .AddrW(AW), .DataW(DW), .CntW(CW), .TimeoutCycles(TO)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata), .o_rsp_error(o_rsp_error), .o_rsp_timeout(o_rsp_timeout),
    .o_psel(o_psel), .o_penable(o_penable), .o_pwrite(o_pwrite),
    .o_paddr(o_paddr), .o_pwdata(o_pwdata),
    .i_pready(i_pready), .i_prdata(i_prdata), .i_pslverr(i_pslverr),
    .i_cnt_clr(i_cnt_clr), .o_txn_cnt(o_txn_cnt), .o_err_cnt(o_err_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // counter model: one increment per finished transfer, saturating
  task automatic model_count(input bit err);
    if (exp_txn < CMAX) exp_txn++;
    if (err && exp_err < CMAX) exp_err++;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_txn_cnt"}, 64'(o_txn_cnt), 64'(exp_txn));
    check({tag, "_err_cnt"}, 64'(o_err_cnt), 64'(exp_err));
  endtask

  // accept cycle plus SETUP cycle; leaves the bench in the first ACCESS cycle's negedge-1
  task automatic drive_req(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    check("idle_req_ready", 64'(o_req_ready), 64'd1);
    check("idle_psel", 64'(o_psel), 64'd0);
    i_req_valid = 1'b1;
    i_req_write = wr;
    i_req_addr  = addr;
    i_req_wdata = wdata;
    @(negedge clk);
    i_req_valid = 1'b0;
    i_req_write = 1'($urandom_range(1, 0));
    i_req_addr  = $urandom;
    i_req_wdata = $urandom;
    check("setup_psel", 64'(o_psel), 64'd1);
    check("setup_penable", 64'(o_penable), 64'd0);
    check("setup_req_ready", 64'(o_req_ready), 64'd0);
    check("setup_paddr", 64'(o_paddr), 64'(addr));
    check("setup_pwrite", 64'(o_pwrite), 64'(wr));
    check("setup_pwdata", 64'(o_pwdata), 64'(wdata));
  endtask

  task automatic check_access(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    check("access_psel", 64'(o_psel), 64'd1);
    check("access_penable", 64'(o_penable), 64'd1);
    check("access_paddr", 64'(o_paddr), 64'(addr));
    check("access_pwrite", 64'(o_pwrite), 64'(wr));
    check("access_pwdata", 64'(o_pwdata), 64'(wdata));
    check("access_rsp_valid", 64'(o_rsp_valid), 64'd0);
  endtask

  // holds the response for rsp_hold cycles (with a competing request), then consumes it
  task automatic finish_rsp(input logic [DW-1:0] exp_rd, input bit exp_e, input bit exp_t,
                            input int rsp_hold);
    for (int h = 0; h < rsp_hold; h++) begin
      i_req_valid = 1'b1;
      i_req_addr  = $urandom;
      @(negedge clk);
      check("hold_rsp_valid", 64'(o_rsp_valid), 64'd1);
      check("hold_rdata", 64'(o_rsp_rdata), 64'(exp_rd));
      check("hold_error", 64'(o_rsp_error), 64'(exp_e));
      check("hold_timeout", 64'(o_rsp_timeout), 64'(exp_t));
      check("hold_req_ready", 64'(o_req_ready), 64'd0);
      check("hold_psel", 64'(o_psel), 64'd0);
    end
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
    check("done_rsp_valid", 64'(o_rsp_valid), 64'd0);
    check("done_req_ready", 64'(o_req_ready), 64'd1);
    check("done_psel", 64'(o_psel), 64'd0);
  endtask

  // driver: one complete transfer with a given number of slave wait states
  task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input int waits, input logic [DW-1:0] rdata, input bit slverr,
                        input int rsp_hold, input bit clr_at_done);
    logic [DW-1:0] exp_rd;
    exp_q.push_back(wr ? '0 : rdata);
    drive_req(wr, addr, wdata);
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      check_access(wr, addr, wdata);
      if (k == waits) begin
        i_pready  = 1'b1;
        i_prdata  = rdata;
        i_pslverr = slverr;
        i_cnt_clr = clr_at_done;
      end else begin
        i_pready  = 1'b0;
        i_prdata  = $urandom;
        i_pslverr = 1'($urandom_range(1, 0));
      end
    end
    @(negedge clk);
    i_pready  = 1'b0;
    i_prdata  = $urandom;
    i_pslverr = 1'($urandom_range(1, 0));
    i_cnt_clr = 1'b0;
    if (clr_at_done) begin
      exp_txn = 0;
      exp_err = 0;
    end else begin
      model_count(slverr);
    end
    exp_rd = exp_q.pop_front();
    check("rsp_valid", 64'(o_rsp_valid), 64'd1);
    check("rsp_psel", 64'(o_psel), 64'd0);
    check("rsp_penable", 64'(o_penable), 64'd0);
    check("rsp_rdata", 64'(o_rsp_rdata), 64'(exp_rd));
    check("rsp_error", 64'(o_rsp_error), 64'(slverr));
    check("rsp_timeout", 64'(o_rsp_timeout), 64'd0);
    check_counters("rsp");
    finish_rsp(exp_rd, slverr, 1'b0, rsp_hold);
  endtask

`ifdef LPDDR_PHY_CFG_APB_TIMEOUT_EN
  // read with pready low for TO ACCESS cycles, optionally rising on the last one
  task automatic do_timeout(input bit late_ready, input logic [DW-1:0] rdata);
    logic [AW-1:0] addr;
    logic [DW-1:0] exp_rd;
    addr = $urandom;
    exp_q.push_back(late_ready ? rdata : '0);
    drive_req(1'b0, addr, 32'h0);
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      check_access(1'b0, addr, 32'h0);
      i_pready  = late_ready && (k == TO - 1);
      i_prdata  = late_ready ? rdata : $urandom;
      i_pslverr = late_ready ? 1'b0 : 1'($urandom_range(1, 0));
    end
    @(negedge clk);
    i_pready  = 1'b0;
    i_pslverr = 1'b0;
    model_count(!late_ready);
    exp_rd = exp_q.pop_front();
    check("to_rsp_valid", 64'(o_rsp_valid), 64'd1);
    check("to_psel", 64'(o_psel), 64'd0);
    check("to_rdata", 64'(o_rsp_rdata), 64'(exp_rd));
    check("to_error", 64'(o_rsp_error), 64'(!late_ready));
    check("to_timeout", 64'(o_rsp_timeout), 64'(!late_ready));
    check_counters("to");
    finish_rsp(exp_rd, !late_ready, !late_ready, 1);
  endtask
`endif

  initial begin
    logic [AW-1:0] r_addr;
    // reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(o_req_ready), 64'd1);
    check("rst_psel", 64'(o_psel), 64'd0);
    check("rst_penable", 64'(o_penable), 64'd0);
    check("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    check("rst_rdata", 64'(o_rsp_rdata), 64'd0);
    check("rst_error", 64'(o_rsp_error), 64'd0);
    check("rst_timeout", 64'(o_rsp_timeout), 64'd0);
    check("rst_paddr", 64'(o_paddr), 64'd0);
    check("rst_pwdata", 64'(o_pwdata), 64'd0);
    check("rst_pwrite", 64'(o_pwrite), 64'd0);
    check_counters("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // single write, best-case latency
    do_txn(1'b1, 32'h0000_1000, 32'hA5A5_5A5A, 0, 32'h1234_5678, 1'b0, 0, 1'b0);
    // read with 3 wait states
    do_txn(1'b0, 32'h0000_2040, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
    // PSLVERR on a read, response held 2 cycles against a waiting request
    do_txn(1'b0, 32'h0000_0FFC, 32'h0, 1, 32'h0BAD_F00D, 1'b1, 2, 1'b0);
    // backpressure for 10 cycles
    do_txn(1'b1, 32'h0000_3000, 32'hCAFE_0001, 2, 32'h0, 1'b0, 10, 1'b0);

`ifdef LPDDR_PHY_CFG_APB_TIMEOUT_EN
    do_timeout(1'b0, 32'h0);
    do_timeout(1'b1, 32'h7777_1111);
`endif

    // random traffic, long enough to saturate the counters
    for (int i = 0; i < 20; i++) begin
      r_addr = $urandom;
      do_txn(1'($urandom_range(1, 0)), r_addr, $urandom, $urandom_range(3, 0), $urandom,
             ($urandom_range(3, 0) == 0), $urandom_range(2, 0), 1'b0);
    end

    // clear coincident with a completion wins, then counting restarts
    do_txn(1'b0, 32'h0000_4000, 32'h0, 1, 32'h5555_AAAA, 1'b1, 0, 1'b1);
    do_txn(1'b0, 32'h0000_4004, 32'h0, 0, 32'h0F0F_0F0F, 1'b1, 0, 1'b0);

    // reset asserted during ACCESS
    drive_req(1'b0, 32'h0000_5000, 32'h0);
    @(negedge clk);
    i_pready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_txn = 0;
    exp_err = 0;
    check("arst_psel", 64'(o_psel), 64'd0);
    check("arst_penable", 64'(o_penable), 64'd0);
    check("arst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    check_counters("arst");
    @(negedge clk);
    rst_n = 1'b1;
    i_pready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
      check("post_rst_psel", 64'(o_psel), 64'd0);
      check("post_rst_req_ready", 64'(o_req_ready), 64'd1);
    end
    i_pready = 1'b0;
    check_counters("post_rst");

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/lpddr_phy_cfg_apb3_initiator.md
# lpddr_phy_cfg_apb3_initiator

APB3 initiator that turns single-beat register requests (valid/ready) into APB3 transfers on the LPDDR PHY configuration target port. It sits inside the LPDDR subsystem on the lpddr clock, between the PHY training/init sequencer (or a debug bridge) and the PHY config APB3 slave. It returns read data and error status, and keeps saturating transaction and error counters.

## Interface
Parameters:
- AddrW, 32, APB3 address width; matches LPDDR_TARG_PHY_CFG_APB3_ADDR_W.
- DataW, 32, APB3 data width; matches LPDDR_TARG_PHY_CFG_APB3_DATA_W.
- CntW, 32, counter width; matches LPDDR_PERF_COUNTER_WIDTH.
- TimeoutCycles, 1024, ACCESS-phase wait limit in cycles, minimum 2. Used only with the timeout macro.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - i_clk, in, 1, lpddr clock.
  - i_rst_n, in, 1, asynchronous active-low reset.
- Request interface:
  - i_req_valid, in, 1, request valid.
  - o_req_ready, out, 1, request accepted.
  - i_req_write, in, 1, 1 = write, 0 = read.
  - i_req_addr, in, AddrW, target address.
  - i_req_wdata, in, DataW, write data.
- Response interface:
  - o_rsp_valid, out, 1, response valid.
  - i_rsp_ready, in, 1, response consumed.
  - o_rsp_rdata, out, DataW, read data; 0 for writes.
  - o_rsp_error, out, 1, PSLVERR seen or timeout.
  - o_rsp_timeout, out, 1, transfer aborted by timeout.
- APB3 interface:
  - o_psel, out, 1, APB3 select.
  - o_penable, out, 1, APB3 enable.
  - o_pwrite, out, 1, APB3 direction.
  - o_paddr, out, AddrW, APB3 address.
  - o_pwdata, out, DataW, APB3 write data.
  - i_pready, in, 1, APB3 ready.
  - i_prdata, in, DataW, APB3 read data.
  - i_pslverr, in, 1, APB3 slave error.
- Counters:
  - i_cnt_clr, in, 1, synchronous clear of both counters.
  - o_txn_cnt, out, CntW, completed transfers.
  - o_err_cnt, out, CntW, errored transfers.

## Operation
- FSM states:
  - IDLE: o_req_ready=1. On i_req_valid, register write/addr/wdata and go to SETUP.
  - SETUP: psel=1, penable=0. Always go to ACCESS.
  - ACCESS: psel=1, penable=1. On i_pready=1:
    - capture i_prdata (reads only; writes return 0) and i_pslverr;
    - go to RESP.
  - RESP: o_rsp_valid=1. On i_rsp_ready go to IDLE.
- o_req_ready is high only in IDLE. At most one transfer is outstanding.
- APB stability: o_paddr, o_pwrite and o_pwdata are driven from the request register. They stay stable from SETUP through the completing ACCESS cycle.
- Response payload: o_rsp_rdata, o_rsp_error and o_rsp_timeout are registered and stable while o_rsp_valid=1.
- Counters:
  - o_txn_cnt increments once per ACCESS exit (completion or timeout).
  - o_err_cnt increments when that exit carries pslverr or timeout.
  - Both saturate at 2^CntW-1.
  - i_cnt_clr has priority over a same-cycle increment; result is 0.
- i_prdata and i_pslverr are ignored outside the completing ACCESS cycle.

## Timing
- Reset values: state IDLE; o_req_ready=1; all other outputs 0, counters included.
- Reset mid-transfer: o_psel and o_penable drop asynchronously at reset assertion. The transfer is lost and no response is produced.
- Best-case latency:
  - request accepted at cycle N;
  - SETUP at N+1;
  - ACCESS with pready=1 at N+2;
  - o_rsp_valid at N+3.
- Each i_pready=0 cycle in ACCESS adds one cycle.
- Throughput: with i_rsp_ready tied high, one request per 4 cycles at best. The next accept is possible at N+4.
- No combinational paths from any input to any output, except o_req_ready, which is a decode of the state register.

## Configuration
- Macro LPDDR_PHY_CFG_APB_TIMEOUT_EN defined:
  - A counter runs in ACCESS while i_pready=0.
  - When the counter reaches TimeoutCycles, drop psel/penable the next cycle and enter RESP with o_rsp_error=1, o_rsp_timeout=1, o_rsp_rdata=0.
  - If i_pready=1 arrives on the limit cycle, it wins: normal completion, no timeout.
  - The counter resets on every SETUP.
- Macro not defined:
  - ACCESS waits indefinitely.
  - o_rsp_timeout is tied to 0 and the counter logic is absent.

## Test plan
- Single write: addr=0x0000_1000, wdata=0xA5A5_5A5A, pready=1 at first ACCESS.
  - psel at N+1, penable at N+2, o_rsp_valid at N+3 with rdata=0, error=0.
  - o_txn_cnt=1.
- Read with 3 wait states: slave returns 0xDEAD_BEEF.
  - o_rsp_valid at N+6 with rdata=0xDEAD_BEEF.
  - paddr/pwrite stable throughout the transfer.
- PSLVERR on a read:
  - o_rsp_error=1, o_rsp_timeout=0.
  - o_err_cnt=1.
  - Next request is accepted only after i_rsp_ready.
- Backpressure: hold i_rsp_ready=0 for 10 cycles.
  - Response payload stays stable.
  - o_req_ready=0 throughout; no new APB transfer starts.
- Timeout (macro on, TimeoutCycles=4), pready held 0:
  - abort after 4 ACCESS cycles;
  - o_rsp_error=1, o_rsp_timeout=1, both counters increment.
  - Repeat with pready=1 on the 4th cycle: normal completion.
- Assert i_rst_n=0 during ACCESS:
  - psel/penable drop immediately; no response afterwards.
  - Counters read 0.
  - Separately, i_cnt_clr coincident with a completion leaves the counters at 0.
